spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter_pkg.sv | 23 ++
 rtl/spi_arbiter_if.sv | 24 ++
 rtl/spi_arbiter_rr_arb2.sv | 30 +++
 rtl/spi_arbiter.sv | 148 ++++++++++++++
 tb/tb_spi_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_arbiter_pkg.sv
// Shared types and constants for the two-requester SPI arbiter.
package spi_arbiter_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CFG_W   = 2;
  localparam int unsigned CKP_BIT = 1;
  localparam int unsigned CPH_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Byte and SPI mode latched from the winning requester
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CFG_W-1:0]  cfg;
  } xfer_t;

endpackage

// File: rtl/spi_arbiter_if.sv
// Link between the arbiter and the shared SPI master engine plus chip selects.
interface spi_arbiter_if;
  import spi_arbiter_pkg::*;

  logic              M_START;
  logic [DATA_W-1:0] M_DATA;
  logic              M_CKP;
  logic              M_CPH;
  logic              M_DONE;
  logic [DATA_W-1:0] M_RX;
  logic              CS0_N;
  logic              CS1_N;

  modport master (
    output M_START, M_DATA, M_CKP, M_CPH, CS0_N, CS1_N,
    input  M_DONE, M_RX
  );

  modport slave (
    input  M_START, M_DATA, M_CKP, M_CPH, CS0_N, CS1_N,
    output M_DONE, M_RX
  );

endinterface

// File: rtl/spi_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer remembers last winner.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt_c
);

  logic last_q;  // 1: requester 1 was served most recently

  always_comb begin
    gnt_c = 2'b00;
    case (req)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = last_q ? 2'b01 : 2'b10;
      default: gnt_c = 2'b00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_q <= 1'b1;
    end else if (update && (gnt_c != 2'b00)) begin
      last_q <= gnt_c[1];
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between two requesters; all outputs come straight from flops.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] TX0,
  input  logic [DATA_W-1:0] TX1,
  input  logic [CFG_W-1:0]  CFG0,
  input  logic [CFG_W-1:0]  CFG1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic              ERR,
  output logic [DATA_W-1:0] RX_DATA,
  spi_arbiter_if.master     spi
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned GAP_W  = 4;

  state_e              state_q, state_d;
  xfer_t               xfer_q, xfer_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          cs_n_q, cs_n_d;
  logic                err_q, err_d;
  logic                m_start_q, m_start_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [1:0]          arb_gnt_c;
  logic                arb_update_c;

  rr_arb2 u_rr_arb2 (
    .CLK    (CLK),
    .RESET  (RESET),
    .req    ({REQ1, REQ0}),
    .update (arb_update_c),
    .gnt_c  (arb_gnt_c)
  );

  // Next state plus next value of every output flop
  always_comb begin
    state_d      = state_q;
    xfer_d       = xfer_q;
    gnt_d        = gnt_q;
    done_d       = 2'b00;
    cs_n_d       = cs_n_q;
    err_d        = 1'b0;
    m_start_d    = 1'b0;
    rx_d         = rx_q;
    wait_cnt_d   = wait_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    arb_update_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_gnt_c != 2'b00) begin
          arb_update_c = 1'b1;
          xfer_d  = arb_gnt_c[1] ? xfer_t'{data: TX1, cfg: CFG1}
                                 : xfer_t'{data: TX0, cfg: CFG0};
          gnt_d   = arb_gnt_c;
          cs_n_d  = ~arb_gnt_c;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        m_start_d = 1'b1;
        state_d   = ST_START;
      end
      ST_START: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the last allowed cycle wins over the timeout
        if (spi.M_DONE || (wait_cnt_q == WAIT_W'(TIMEOUT - 1))) begin
          done_d    = gnt_q;
          err_d     = ~spi.M_DONE;
          rx_d      = spi.M_DONE ? spi.M_RX : rx_q;
          gnt_d     = 2'b00;
          cs_n_d    = 2'b11;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      xfer_q     <= '0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      cs_n_q     <= 2'b11;
      err_q      <= 1'b0;
      m_start_q  <= 1'b0;
      rx_q       <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      xfer_q     <= xfer_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      err_q      <= err_d;
      m_start_q  <= m_start_d;
      rx_q       <= rx_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign GNT0        = gnt_q[0];
  assign GNT1        = gnt_q[1];
  assign DONE0       = done_q[0];
  assign DONE1       = done_q[1];
  assign ERR         = err_q;
  assign RX_DATA     = rx_q;
  assign spi.M_START = m_start_q;
  assign spi.M_DATA  = xfer_q.data;
  assign spi.M_CKP   = xfer_q.cfg[CKP_BIT];
  assign spi.M_CPH   = xfer_q.cfg[CPH_BIT];
  assign spi.CS0_N   = cs_n_q[0];
  assign spi.CS1_N   = cs_n_q[1];

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter; the bench plays both requesters and the SPI master.
module tb_spi_arbiter;
  import spi_arbiter_pkg::*;

  localparam int unsigned G  = 2;
  localparam int unsigned TO = 32;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ0, REQ1;
  logic [7:0] TX0, TX1;
  logic [1:0] CFG0, CFG1;
  logic       GNT0, GNT1, DONE0, DONE1, ERR;
  logic [7:0] RX_DATA;

  spi_arbiter_if spi ();

  spi_arbiter #(.GAP_CYCLES(G), .TIMEOUT(TO)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .REQ0    (REQ0),
    .REQ1    (REQ1),
    .TX0     (TX0),
    .TX1     (TX1),
    .CFG0    (CFG0),
    .CFG1    (CFG1),
    .GNT0    (GNT0),
    .GNT1    (GNT1),
    .DONE0   (DONE0),
    .DONE1   (DONE1),
    .ERR     (ERR),
    .RX_DATA (RX_DATA),
    .spi     (spi.master)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive and sample 1 time unit after each rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_start(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (spi.M_START) begin
        ok = 1'b1;
        break;
      end
      step(1);
      cyc++;
    end
  endtask

  // Exclusivity of grants, chip selects and completions
  always @(negedge CLK) begin
    if (!RESET) begin
      if ((!spi.CS0_N && !spi.CS1_N) || (GNT0 && GNT1) || (DONE0 && DONE1)) overlap++;
    end
  end

  initial begin
    int cyc;
    bit ok;
    int n;
    int run;
    int stray;
    int who;
    int exp_order[3];
    exp_order = '{0, 1, 0};

    REQ0 = 1'b0; REQ1 = 1'b0;
    TX0 = 8'h00; TX1 = 8'h00; CFG0 = 2'b00; CFG1 = 2'b00;
    spi.M_DONE = 1'b0; spi.M_RX = 8'h00;
    step(2);

    // Reset values
    check("rst_ctl", 32'({GNT0, GNT1, DONE0, DONE1, ERR, spi.M_START, spi.CS0_N, spi.CS1_N,
                          spi.M_CKP, spi.M_CPH}), 32'b0000001100);
    check("rst_rx", 32'(RX_DATA), 32'h0);
    check("rst_mdata", 32'(spi.M_DATA), 32'h0);

    // Single request from 0, mode 01, response after 20 cycles
    RESET = 1'b0;
    REQ0 = 1'b1; TX0 = 8'hA5; CFG0 = 2'b01;
    step(1);
    check("t1_setup", 32'({GNT0, GNT1, spi.CS0_N, spi.CS1_N, spi.M_START}), 32'b10010);
    check("t1_mdata", 32'(spi.M_DATA), 32'hA5);
    check("t1_mode", 32'({spi.M_CKP, spi.M_CPH}), 32'b01);
    step(1);
    check("t1_mstart", 32'(spi.M_START), 32'h1);
    step(1);
    check("t1_mstart_once", 32'(spi.M_START), 32'h0);
    check("t1_wait_hold", 32'({spi.M_DATA, spi.CS0_N, spi.CS1_N, spi.M_CPH}), 32'({8'hA5, 3'b011}));
    step(18);
    spi.M_DONE = 1'b1; spi.M_RX = 8'h3C;
    step(1);
    spi.M_DONE = 1'b0;
    REQ0 = 1'b0;
    check("t1_done", 32'({DONE0, DONE1, ERR}), 32'b100);
    check("t1_rx", 32'(RX_DATA), 32'h3C);
    check("t1_release", 32'({GNT0, spi.CS0_N, spi.CS1_N}), 32'b011);
    step(1);
    check("t1_done_pulse", 32'(DONE0), 32'h0);

    // Requester 1 with a silent SPI master: timeout, RX_DATA kept
    REQ1 = 1'b1; TX1 = 8'h5A; CFG1 = 2'b10;
    wait_start(cyc, ok);
    check("t2_start_seen", 32'(ok), 32'h1);
    check("t2_cs", 32'({spi.CS0_N, spi.CS1_N, GNT1}), 32'b101);
    check("t2_mode", 32'({spi.M_DATA, spi.M_CKP, spi.M_CPH}), 32'({8'h5A, 2'b10}));
    n = 0;
    while (!DONE1 && n < 100) begin
      step(1);
      n++;
    end
    check("t2_timeout_lat", 32'(n), 32'(TO + 1));
    check("t2_err", 32'({DONE1, DONE0, ERR}), 32'b101);
    check("t2_rx_kept", 32'(RX_DATA), 32'h3C);
    REQ1 = 1'b0;

    // M_DONE on the last allowed wait cycle is a success
    REQ0 = 1'b1; TX0 = 8'h11; CFG0 = 2'b00;
    wait_start(cyc, ok);
    check("t3_start_seen", 32'(ok), 32'h1);
    step(TO);
    check("t3_no_early_to", 32'({DONE0, DONE1}), 32'b00);
    spi.M_DONE = 1'b1; spi.M_RX = 8'h77;
    step(1);
    spi.M_DONE = 1'b0;
    check("t3_edge_ok", 32'({DONE0, ERR}), 32'b10);
    check("t3_rx", 32'(RX_DATA), 32'h77);

    // REQ0 still held: chip-select high run and a stray M_DONE in GAP.
    // The run covers the GAP cycles plus the IDLE arbitration cycle.
    run = 0;
    stray = 0;
    spi.M_DONE = 1'b1; spi.M_RX = 8'hEE;
    for (int i = 0; i < 20 && spi.CS0_N; i++) begin
      run++;
      step(1);
      spi.M_DONE = 1'b0;
      if (DONE0 || DONE1) stray++;
    end
    check("t4_gap_run", 32'(run), 32'(G + 1));
    check("t4_stray_done", 32'(stray), 32'h0);
    check("t4_rx_kept", 32'(RX_DATA), 32'h77);
    step(1);
    check("t4_mstart", 32'(spi.M_START), 32'h1);
    step(3);
    spi.M_DONE = 1'b1; spi.M_RX = 8'h42;
    step(1);
    spi.M_DONE = 1'b0;
    REQ0 = 1'b0;
    check("t4_done", 32'({DONE0, ERR, RX_DATA}), 32'({2'b10, 8'h42}));
    step(G + 2);

    // Reset in WAIT aborts silently
    REQ1 = 1'b1; TX1 = 8'h99;
    wait_start(cyc, ok);
    check("t5_start_seen", 32'(ok), 32'h1);
    step(3);
    RESET = 1'b1; REQ1 = 1'b0;
    step(1);
    check("t5_rst_ctl", 32'({GNT0, GNT1, DONE0, DONE1, ERR, spi.M_START, spi.CS0_N, spi.CS1_N}),
          32'b00000011);
    check("t5_rst_rx", 32'(RX_DATA), 32'h0);

    // Post-reset tie, both held: order 0,1,0
    RESET = 1'b0;
    REQ0 = 1'b1; TX0 = 8'hC0; CFG0 = 2'b11;
    REQ1 = 1'b1; TX1 = 8'hC1; CFG1 = 2'b00;
    for (int t = 0; t < 3; t++) begin
      wait_start(cyc, ok);
      check("t6_start_seen", 32'(ok), 32'h1);
      who = !spi.CS0_N ? 0 : (!spi.CS1_N ? 1 : 9);
      check("t6_order", 32'(who), 32'(exp_order[t]));
      check("t6_mdata", 32'(spi.M_DATA), exp_order[t] == 1 ? 32'hC1 : 32'hC0);
      step(2);
      spi.M_DONE = 1'b1; spi.M_RX = 8'(8'h10 + t);
      step(1);
      spi.M_DONE = 1'b0;
      check("t6_done", 32'({DONE1, DONE0, ERR}), exp_order[t] == 1 ? 32'b100 : 32'b010);
      check("t6_rx", 32'(RX_DATA), 32'(8'h10 + t));
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    step(5);
    check("excl_overlap", 32'(overlap), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
